// File: rtl/rng_table_writer_if.sv
// Stream-in plus memory-write bus for rng_table_writer.
// master = the writer, slave = the seed source / memory side.
interface rng_table_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic              wr_en;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        input  in_data, in_valid, mem_data_out,
        output in_ready, address, wr_en, mem_data_in
    );

    modport slave (
        output in_data, in_valid, mem_data_out,
        input  in_ready, address, wr_en, mem_data_in
    );
endinterface

// File: rtl/rng_table_writer.sv
// Fills DEPTH consecutive words from BASE_ADDR with streamed seed/table data.
// Optional XOR readback check of the filled table when WRITER_VERIFY_EN is defined.
module rng_table_writer #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                DEPTH     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    rng_table_writer_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                error
);
`ifdef WRITER_VERIFY_EN
    typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
`endif

    // ptr is one bit wider than the address so a full 2^ADDR_W fill is expressible
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH);

    state_t          state;
    logic [ADDR_W:0] ptr;
    logic            xfer;

    assign bus.in_ready = (state == FILL) && (ptr < LAST);
    assign xfer         = bus.in_valid & bus.in_ready;

`ifdef WRITER_VERIFY_EN
    localparam int STAGES = 1;

    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] chk;
    logic [DATA_W-1:0] rb;
    // [0]: a read address is on the bus, [1]: its data is on mem_data_out
    logic [STAGES:0]   vld_pipe;
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.mem_data_out;
    assign error        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            bus.address     <= '0;
            bus.wr_en       <= 1'b0;
            bus.mem_data_in <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
`ifdef WRITER_VERIFY_EN
            rd_ptr          <= '0;
            chk             <= '0;
            rb              <= '0;
            vld_pipe        <= '0;
            error           <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            bus.wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        ptr   <= '0;
                        busy  <= 1'b1;
`ifdef WRITER_VERIFY_EN
                        chk   <= '0;
                        rb    <= '0;
                        error <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    if (xfer) begin
                        bus.wr_en       <= 1'b1;
                        bus.address     <= BASE_ADDR + ptr[ADDR_W-1:0];
                        bus.mem_data_in <= bus.in_data;
                        ptr             <= ptr + 1'b1;
`ifdef WRITER_VERIFY_EN
                        chk             <= chk ^ bus.in_data;
                        if (ptr + 1'b1 == LAST) begin
                            state    <= VERIFY;
                            rd_ptr   <= '0;
                            vld_pipe <= '0;
                        end
`else
                        if (ptr + 1'b1 == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef WRITER_VERIFY_EN
                VERIFY: begin
                    vld_pipe <= {vld_pipe[0], rd_ptr < LAST};
                    if (rd_ptr < LAST) begin
                        bus.address <= BASE_ADDR + rd_ptr[ADDR_W-1:0];
                        rd_ptr      <= rd_ptr + 1'b1;
                    end
                    if (vld_pipe[1])
                        rb <= rb ^ bus.mem_data_out;
                    // last read's data is on the bus: fold it in and compare in one step
                    if (vld_pipe == 2'b10 && rd_ptr == LAST) begin
                        error <= ((rb ^ bus.mem_data_out) != chk);
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rng_table_writer.sv
// Directed bench: two writers (base 0 and base FFFE, depth 4) with memory models.
module tb_rng_table_writer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, done_a, error_a, busy_b, done_b, error_b;
    logic corrupt = 1'b0;
    int   errs = 0, checks = 0, cyc = 0;
    int   dn_a = 0, dn_b = 0;

    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];
    logic [15:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
    int          qa_cyc[$];

`ifdef WRITER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    rng_table_writer_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
    rng_table_writer_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

    rng_table_writer #(.ADDR_W(16), .DATA_W(16), .BASE_ADDR(16'h0000), .DEPTH(4)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .bus(ifa),
        .busy(busy_a), .done(done_a), .error(error_a)
    );
    rng_table_writer #(.ADDR_W(16), .DATA_W(16), .BASE_ADDR(16'hFFFE), .DEPTH(4)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .bus(ifb),
        .busy(busy_b), .done(done_b), .error(error_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // synchronous memories; address 2 of mem_a can be corrupted on write
    always @(posedge clock) begin
        if (ifa.wr_en)
            mem_a[ifa.address] <= (corrupt && ifa.address == 16'd2) ? (ifa.mem_data_in ^ 16'h5A5A) : ifa.mem_data_in;
        ifa.mem_data_out <= mem_a[ifa.address];
        if (ifb.wr_en) mem_b[ifb.address] <= ifb.mem_data_in;
        ifb.mem_data_out <= mem_b[ifb.address];
    end

    always @(negedge clock) begin
        if (ifa.wr_en) begin
            qa_addr.push_back(ifa.address);
            qa_data.push_back(ifa.mem_data_in);
            qa_cyc.push_back(cyc);
        end
        if (ifb.wr_en) begin
            qb_addr.push_back(ifb.address);
            qb_data.push_back(ifb.mem_data_in);
        end
        if (done_a) dn_a++;
        if (done_b) dn_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [15:0] d, input logic s);
        if (sel) begin ifb.in_valid = v; ifb.in_data = d; start_b = s; end
        else     begin ifa.in_valid = v; ifa.in_data = d; start_a = s; end
    endtask

    task automatic fill(input bit sel, input logic [15:0] w [4], input int gap_at, input int restart_at);
        @(posedge clock); #1 drive(sel, 1'b0, 16'h0, 1'b1);
        @(posedge clock); #1 drive(sel, 1'b0, 16'h0, 1'b0);
        check("rdy_fill", sel ? ifb.in_ready : ifa.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == gap_at) begin
                drive(sel, 1'b0, 16'h0, 1'b0);
                repeat (2) @(posedge clock);
                #1;
            end
            drive(sel, 1'b1, w[i], i == restart_at);
            @(posedge clock); #1;
        end
        drive(sel, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic wait_done(input bit sel, output logic e);
        int n = 0;
        while (!(sel ? done_b : done_a) && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        check("done_seen", sel ? done_b : done_a, 1);
        check("busy_at_done", sel ? busy_b : busy_a, 0);
        e = sel ? error_b : error_a;
        repeat (3) @(posedge clock);
        #1;
        check("rdy_after", sel ? ifb.in_ready : ifa.in_ready, 0);
    endtask

    task automatic check_q(input bit sel, input string tag, input int s, input logic [15:0] base,
                           input logic [15:0] w [4]);
        int sz;
        logic [15:0] a;
        sz = sel ? qb_addr.size() : qa_addr.size();
        check({tag, "_cnt"}, sz - s, 4);
        for (int i = 0; i < 4; i++) begin
            if (s + i < sz) begin
                a = base + 16'(i);
                check({tag, "_addr"}, sel ? qb_addr[s+i] : qa_addr[s+i], a);
                check({tag, "_data"}, sel ? qb_data[s+i] : qa_data[s+i], w[i]);
            end
        end
    endtask

    logic [15:0] w1 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] w2 [4] = '{16'hBEEF, 16'h0001, 16'h8000, 16'hC0DE};
    logic [15:0] w3 [4] = '{16'hA001, 16'hA002, 16'h0F0F, 16'h7777};

    initial begin
        int s, d0;
        logic e;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b0);

        // 1: reset held 2 cycles, start asserted alongside reset must not take effect
        start_a = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0; start_a = 1'b0;
        @(negedge clock);
        check("rst_addr", ifa.address, 0);
        check("rst_wr_en", ifa.wr_en, 0);
        check("rst_wdata", ifa.mem_data_in, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_error", error_a, 0);
        check("rst_ready", ifa.in_ready, 0);

        // 2: plain back-to-back fill
        s = qa_addr.size(); d0 = dn_a;
        fill(1'b0, w1, -1, -1);
        wait_done(1'b0, e);
        check("t2_err", e, 0);
        check_q(1'b0, "t2", s, 16'h0000, w1);
        if (qa_cyc.size() >= s + 4) check("t2_b2b", qa_cyc[s+3] - qa_cyc[s], 3);
        check("t2_dones", dn_a - d0, 1);
        for (int i = 0; i < 4; i++) check("t2_mem", mem_a[i], w1[i]);

        // 3: two-cycle in_valid gap after the 2nd word
        s = qa_addr.size(); d0 = dn_a;
        fill(1'b0, w2, 2, -1);
        wait_done(1'b0, e);
        check_q(1'b0, "t3", s, 16'h0000, w2);
        if (qa_cyc.size() >= s + 3) check("t3_gap", qa_cyc[s+2] - qa_cyc[s+1], 3);
        check("t3_dones", dn_a - d0, 1);

        // 4: address wrap from FFFE
        s = qb_addr.size(); d0 = dn_b;
        fill(1'b1, w3, -1, -1);
        wait_done(1'b1, e);
        check_q(1'b1, "t4", s, 16'hFFFE, w3);
        check("t4_dones", dn_b - d0, 1);
        check("t4_mem0", mem_b[0], w3[2]);

        // 5: reset after the 2nd write aborts the fill
        s = qa_addr.size(); d0 = dn_a;
        @(posedge clock); #1 start_a = 1'b1;
        @(posedge clock); #1 start_a = 1'b0;
        ifa.in_valid = 1'b1; ifa.in_data = 16'hD001;
        @(posedge clock); #1 ifa.in_data = 16'hD002;
        @(posedge clock); #1;
        check("t5_wr2", ifa.wr_en, 1);
        ifa.in_data = 16'hD003; reset = 1'b1;
        @(posedge clock); #1;
        check("t5_wr_after_rst", ifa.wr_en, 0);
        check("t5_busy_after_rst", busy_a, 0);
        reset = 1'b0; ifa.in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("t5_wcnt", qa_addr.size() - s, 2);
        check("t5_no_done", dn_a - d0, 0);
        s = qa_addr.size(); d0 = dn_a;
        fill(1'b0, w3, -1, -1);
        wait_done(1'b0, e);
        check_q(1'b0, "t5_refill", s, 16'h0000, w3);
        check("t5_dones", dn_a - d0, 1);

        // 6: start during busy is ignored
        s = qa_addr.size(); d0 = dn_a;
        fill(1'b0, w1, -1, 1);
        wait_done(1'b0, e);
        check_q(1'b0, "t6", s, 16'h0000, w1);
        check("t6_dones", dn_a - d0, 1);

        // 7: corrupted word flagged by readback (only with the verify build), then a clean run
        corrupt = 1'b1;
        fill(1'b0, w2, -1, -1);
        wait_done(1'b0, e);
        check("t7_err_corrupt", e, VER);
        check("t7_err_sticky", error_a, VER);
        corrupt = 1'b0;
        fill(1'b0, w2, -1, -1);
        wait_done(1'b0, e);
        check("t7_err_clean", e, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
